// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the franken_riscv run controller.
package run_ctrl_pkg;

  // Operating modes, encoded as they appear on the mode pins.
  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_DIV  = 2'b01,
    MODE_STEP = 2'b10,
    MODE_HALT = 2'b11
  } run_mode_t;

  // Single-step handshake: waiting for a press, or waiting for the release.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_HELD = 1'b1
  } step_state_t;

  // Flops in each clock-domain-crossing synchroniser.
  localparam int SYNC_STAGES = 2;

  // Width of a counter that must reach n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchronises the raw button into clk and only
// accepts a new level once it has been stable for DEB_CYCLES cycles.
// Produces the accepted level and a one-cycle pulse on each accepted press.
module btn_debounce
  import run_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int            DW       = cnt_width(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]          stable_cnt;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  // Count consecutive cycles the synchronised button disagrees with the
  // accepted level; any agreeing sample (a bounce) restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_cnt <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (btn_s == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DEB_LAST) begin
        stable_cnt <= '0;
        level      <= btn_s;
        rise       <= btn_s;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/run_ctrl.sv
// Run controller for franken_riscv: releases the core reset after a
// power-on delay and issues one-cycle clock-enable ticks according to the
// selected mode (free run, divided, single step, halt), counting every tick.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DIV_W      = 32,
  parameter int POR_CYCLES = 16,
  parameter int DEB_CYCLES = 270000,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_value,
  input  logic             step_btn,
  output logic             core_resetn,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic             halted
);

  localparam int            PW       = cnt_width(POR_CYCLES);
  localparam logic [PW-1:0] POR_LAST = PW'(POR_CYCLES - 1);

  logic [SYNC_STAGES-1:0] rst_sync_q;
  logic                   rst_sync_n;
  logic [PW-1:0]          por_cnt;
  logic [DIV_W-1:0]       div_cnt;
  logic                   div_hit;
  step_state_t            step_state;
  run_mode_t              mode_q;
  run_mode_t              mode_now;
  logic                   mode_chg;
  logic                   btn_level;
  logic                   btn_rise;
  logic                   tick_fire;

  assign mode_now = run_mode_t'(mode);
  assign mode_chg = (mode_now != mode_q);
  assign div_hit  = (div_cnt >= div_value);
  assign halted   = ~core_resetn | (mode_now == MODE_HALT);

  // Reset synchroniser: assertion is immediate, release is aligned to clk.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync_n = rst_sync_q[SYNC_STAGES-1];

  // Power-on delay: core_resetn rises on the POR_CYCLES-th clk after the
  // synchronised release and then stays high until the next reset.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      por_cnt     <= '0;
      core_resetn <= 1'b0;
    end else if (!core_resetn) begin
      if (por_cnt == POR_LAST) begin
        core_resetn <= 1'b1;
      end else begin
        por_cnt <= por_cnt + 1'b1;
      end
    end
  end

  // Button path; its state survives mode changes so a held button cannot
  // fake a fresh press when entering STEP.
  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_sync_n),
    .btn  (step_btn),
    .level(btn_level),
    .rise (btn_rise)
  );

  // Decide whether this cycle issues a tick; never while the core is held
  // in reset and never in the cycle a mode change is seen.
  always_comb begin
    tick_fire = 1'b0;
    if (core_resetn && !mode_chg) begin
      case (mode_now)
        MODE_RUN:  tick_fire = 1'b1;
        MODE_DIV:  tick_fire = div_hit;
        MODE_STEP: tick_fire = (step_state == S_IDLE) && btn_rise;
        default:   tick_fire = 1'b0;
      endcase
    end
  end

  // Track the previous mode and run the period divider; the compare is
  // >= so lowering div_value below the running count reloads next cycle.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      mode_q  <= MODE_RUN;
      div_cnt <= '0;
    end else begin
      mode_q <= mode_now;
      if (core_resetn) begin
        if (mode_chg) begin
          div_cnt <= '0;
        end else if (mode_now == MODE_DIV) begin
          div_cnt <= div_hit ? '0 : div_cnt + 1'b1;
        end
      end
    end
  end

  // Step FSM: one tick per accepted press, re-armed only by a release.
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      step_state <= S_IDLE;
    end else if (core_resetn) begin
      if (mode_chg) begin
        step_state <= S_IDLE;
      end else if (mode_now == MODE_STEP) begin
        if (step_state == S_IDLE) begin
          if (btn_rise) begin
            step_state <= S_HELD;
          end
        end else if (!btn_level) begin
          step_state <= S_IDLE;
        end
      end
    end
  end

  // Registered tick and the running tick count (wraps naturally).
  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      tick <= tick_fire;
      if (tick_fire) begin
        tick_count <= tick_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: a behavioural model runs alongside two
// DUT builds (32-bit and 4-bit tick counters) and is compared every cycle,
// with directed scenarios adding hand-computed expectations.
module tb_run_ctrl;

  localparam int DIV_W = 32;
  localparam int POR   = 16;
  localparam int DEB   = 4;
  localparam int CNT_W = 32;
  localparam int CNT_S = 4;

  logic             clk       = 1'b0;
  logic             resetn    = 1'b0;
  logic [1:0]       mode      = 2'd0;
  logic [DIV_W-1:0] div_value = '0;
  logic             step_btn  = 1'b0;

  logic             core_resetn, tick, halted;
  logic [CNT_W-1:0] tick_count;
  logic             core_resetn_s, tick_s, halted_s;
  logic [CNT_S-1:0] tick_count_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  run_ctrl #(.DIV_W(DIV_W), .POR_CYCLES(POR), .DEB_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .mode(mode), .div_value(div_value), .step_btn(step_btn),
    .core_resetn(core_resetn), .tick(tick), .tick_count(tick_count), .halted(halted)
  );

  run_ctrl #(.DIV_W(DIV_W), .POR_CYCLES(POR), .DEB_CYCLES(DEB), .CNT_W(CNT_S)) dut_s (
    .clk(clk), .resetn(resetn), .mode(mode), .div_value(div_value), .step_btn(step_btn),
    .core_resetn(core_resetn_s), .tick(tick_s), .tick_count(tick_count_s), .halted(halted_s)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               m_rel;      // clk edges seen since resetn went high
  logic [1:0]       m_bs;       // button delayed through the synchroniser
  logic             m_lvl;      // accepted button level
  logic             m_rise;     // accepted press, visible the edge after
  logic             m_hist[$];  // recent synchronised samples
  logic [1:0]       m_prev;
  logic [DIV_W-1:0] m_cnt;
  logic             m_held;
  logic             m_tick;
  logic [CNT_W-1:0] m_count;
  bit               rs_on, cr_on, t_m, all_diff;
  logic             syn;

  task automatic m_reset();
    m_rel = 0; m_bs = 2'b00; m_lvl = 1'b0; m_rise = 1'b0; m_hist.delete();
    m_prev = 2'd0; m_cnt = '0; m_held = 1'b0; m_tick = 1'b0; m_count = '0;
  endtask

  initial m_reset();

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_reset();
    end else begin
      rs_on = (m_rel >= 2);
      cr_on = (m_rel >= 2 + POR);
      t_m   = 1'b0;
      if (rs_on) begin
        if (cr_on) begin
          if (mode != m_prev) begin
            m_cnt = '0; m_held = 1'b0;
          end else begin
            case (mode)
              2'd0: t_m = 1'b1;
              2'd1: if (m_cnt >= div_value) begin t_m = 1'b1; m_cnt = '0; end
                    else m_cnt = m_cnt + 1;
              2'd2: if (!m_held && m_rise) begin t_m = 1'b1; m_held = 1'b1; end
                    else if (m_held && !m_lvl) m_held = 1'b0;
              default: ;
            endcase
          end
        end
        m_prev = mode;
        // debouncer: flip once the last DEB synchronised samples all disagree
        syn  = m_bs[1];
        m_bs = {m_bs[0], step_btn};
        m_hist.push_back(syn);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        m_rise = 1'b0;
        all_diff = (m_hist.size() == DEB);
        foreach (m_hist[i]) if (m_hist[i] == m_lvl) all_diff = 1'b0;
        if (all_diff) begin
          m_lvl = syn; m_rise = syn; m_hist.delete();
        end
      end
      m_tick = t_m;
      if (t_m) m_count = m_count + 1;
      if (m_rel < 100000) m_rel++;
    end
  end

  // every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    chk("cyc core_resetn", core_resetn, (m_rel >= 2 + POR));
    chk("cyc tick", tick, m_tick);
    chk("cyc tick_count", tick_count, m_count);
    chk("cyc halted", halted, (m_rel < 2 + POR) || (mode == 2'd3));
    chk("cyc small tick_count", tick_count_s, m_count[CNT_S-1:0]);
    chk("cyc small tick", tick_s, m_tick);
  end

  // ---------------- directed scenarios ----------------
  task automatic hold_reset(input logic [1:0] md, input logic [DIV_W-1:0] dv);
    @(negedge clk);
    resetn = 1'b0; mode = md; div_value = dv; step_btn = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic release_and_por(input string tag);
    resetn = 1'b1;
    repeat (17) @(negedge clk);
    chk({tag, " core_resetn before POR"}, core_resetn, 1'b0);
    @(negedge clk);
    chk({tag, " core_resetn after POR"}, core_resetn, 1'b1);
    chk({tag, " tick at POR"}, tick, 1'b0);
  endtask

  logic [11:0] pat12;
  logic [3:0]  pat4;
  logic [4:0]  pat5;

  initial begin
    // 1: reset values, POR delay, free run
    hold_reset(2'd0, '0);
    chk("rst core_resetn", core_resetn, 1'b0);
    chk("rst tick", tick, 1'b0);
    chk("rst tick_count", tick_count, 64'd0);
    chk("rst halted", halted, 1'b1);
    release_and_por("t1");
    repeat (10) @(negedge clk);
    chk("t1 tick", tick, 1'b1);
    chk("t1 tick_count", tick_count, 64'd10);

    // 2: divider, lowering div_value mid-count
    hold_reset(2'd1, 32'd3);
    release_and_por("t2");
    for (int i = 0; i < 12; i++) begin @(negedge clk); pat12[i] = tick; end
    chk("t2 div3 pattern", pat12, 12'h888);
    repeat (2) @(negedge clk);
    div_value = 32'd0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); pat4[i] = tick; end
    chk("t2 div0 pattern", pat4, 4'hF);
    div_value = 32'd3;
    repeat (3) @(negedge clk);
    div_value = 32'd1;
    for (int i = 0; i < 5; i++) begin @(negedge clk); pat5[i] = tick; end
    chk("t2 div1 after cnt3 pattern", pat5, 5'h15);
    chk("t2 tick_count", tick_count, 64'd10);

    // 3: single step with bounce, hold, mode change while held
    hold_reset(2'd2, '0);
    release_and_por("t3");
    @(negedge clk); step_btn = 1'b1;
    @(negedge clk); step_btn = 1'b0;
    @(negedge clk); step_btn = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3 first press count", tick_count, 64'd1);
    step_btn = 1'b0;
    repeat (10) @(negedge clk);
    chk("t3 release count", tick_count, 64'd1);
    step_btn = 1'b1;
    repeat (10) @(negedge clk);
    chk("t3 second press count", tick_count, 64'd2);
    mode = 2'd0;
    repeat (3) @(negedge clk);
    mode = 2'd2;
    repeat (10) @(negedge clk);
    chk("t3 held through mode change", tick_count, 64'd4);
    step_btn = 1'b0;
    repeat (10) @(negedge clk);
    step_btn = 1'b1;
    repeat (10) @(negedge clk);
    chk("t3 third press count", tick_count, 64'd5);

    // 4: halt and return to divide
    hold_reset(2'd1, 32'd3);
    release_and_por("t4");
    repeat (10) @(negedge clk);
    chk("t4 count before halt", tick_count, 64'd2);
    mode = 2'd3;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("t4 halt tick", tick, 1'b0);
      chk("t4 halted", halted, 1'b1);
    end
    chk("t4 count after halt", tick_count, 64'd2);
    mode = 2'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4 no early tick", tick, 1'b0);
    end
    @(negedge clk);
    chk("t4 first tick after halt", tick, 1'b1);
    chk("t4 count after return", tick_count, 64'd3);

    // 5: asynchronous reset mid-divide and mid-press
    hold_reset(2'd1, 32'd3);
    release_and_por("t5");
    repeat (4) @(negedge clk);
    chk("t5 tick before reset", tick, 1'b1);
    chk("t5 count before reset", tick_count, 64'd1);
    #2 resetn = 1'b0;
    #1;
    chk("t5 async core_resetn", core_resetn, 1'b0);
    chk("t5 async tick", tick, 1'b0);
    chk("t5 async tick_count", tick_count, 64'd0);
    chk("t5 async halted", halted, 1'b1);
    hold_reset(2'd0, '0);
    release_and_por("t5r");
    repeat (10) @(negedge clk);
    chk("t5r tick_count", tick_count, 64'd10);
    hold_reset(2'd2, '0);
    release_and_por("t5s");
    step_btn = 1'b1;
    repeat (4) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("t5s async tick_count", tick_count, 64'd0);
    hold_reset(2'd2, '0);
    release_and_por("t5s2");
    repeat (20) @(negedge clk);
    chk("t5s pending press discarded", tick_count, 64'd0);

    // 6: 4-bit counter wrap
    hold_reset(2'd0, '0);
    release_and_por("t6");
    repeat (15) @(negedge clk);
    chk("t6 small count 15", tick_count_s, 64'd15);
    @(negedge clk);
    chk("t6 small count wraps to 0", tick_count_s, 64'd0);
    @(negedge clk);
    chk("t6 small count 1", tick_count_s, 64'd1);
    chk("t6 wide count 17", tick_count, 64'd17);
    chk("t6 no X", {63'd0, $isunknown({core_resetn_s, tick_s, tick_count_s, halted_s})}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
